tomasulo_rob: RTL and testbench
===============================

Name: tomasulo_rob

Overview:
Reorder buffer that sits directly downstream of the tomasulo decode/issue front end. It accepts decoded instructions (func, rd) in program order and hands back a 3-bit ROB tag that the reservation stations use as a rename tag. It captures results broadcast on the common data bus (CDB), serves operand-lookup queries for the issue logic, and retires entries in order, one per cycle, to the register bank or the store path. It flushes the whole window when a mispredicted branch reaches the head.

Parameters:
DEPTH, 8, number of ROB entries; must be a power of two.
TAG_W, 3, tag/pointer width; log2(DEPTH).
DATA_W, 16, result width.
REG_W, 4, architectural register index width.

Ports:
clk1  input  1  sole clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
alloc_valid  input  1  dispatch requests a new entry.
alloc_ready  output  1  entry can be accepted this cycle (combinational).
alloc_func  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 load, 0101 store, 0110 beq, 0111 bneq.
alloc_rd  input  REG_W  destination register, or address/immediate field.
alloc_tag  output  TAG_W  tag given to the allocating instruction; equals the tail pointer.
cdb_valid  input  1  result broadcast is valid.
cdb_tag  input  TAG_W  ROB tag of the broadcast result.
cdb_value  input  DATA_W  result value.
cdb_mispredict  input  1  branch result was mispredicted; meaningful only for 0110/0111.
qa_tag, qb_tag  input  TAG_W  operand lookup tags.
qa_ready, qb_ready  output  1  value available for the queried tag (combinational).
qa_value, qb_value  output  DATA_W  value for the queried tag (combinational).
commit_valid  output  1  one-cycle retire pulse (registered).
commit_tag  output  TAG_W  tag of the retired entry.
commit_rd  output  REG_W  rd field of the retired entry.
commit_value  output  DATA_W  result of the retired entry.
commit_wen  output  1  register-bank write; set for func 0000–0100.
commit_store  output  1  set for func 0101.
flush  output  1  one-cycle pulse (registered) when a mispredicted branch retires.
count  output  TAG_W+1  number of occupied entries.
empty, full  output  1  count==0 and count==DEPTH, respectively.

Behaviour:
- Entry fields: valid, done, mispredict, func[3:0], rd, value.
- Reset (async, rst_n=0):
  - All entries cleared: valid=0, done=0.
  - head=tail=count=0.
  - All registered outputs 0; empty=1, full=0, alloc_ready=1.
- Reset asserted mid-operation discards everything in flight, with no commit or flush pulse.
- Allocate: the handshake fires when alloc_valid && alloc_ready.
  - At the edge, entry[tail] gets valid=1, done=0, mispredict=0, func and rd captured; tail is incremented mod DEPTH.
  - alloc_tag = tail before the edge.
- alloc_ready = !full && !flush_now. flush_now is combinational: head entry valid && done && mispredict && func in {0110, 0111}.
  - When full, allocation is refused even if a commit happens in the same cycle.
- CDB write: if cdb_valid and entry[cdb_tag].valid, then at the edge done=1, value=cdb_value, mispredict=cdb_mispredict.
  - Broadcasts to invalid entries are ignored.
  - A second broadcast to an already-done entry overwrites it.
- Commit: if entry[head] is valid && done at the edge:
  - commit_* outputs are registered from that entry and commit_valid=1 for exactly one cycle.
  - entry[head].valid is cleared and head is incremented mod DEPTH.
  - At most one commit per cycle. A CDB write to the head entry makes it eligible on the following edge, never the same one.
  - For branches (0110/0111): commit_wen=0, commit_store=0, commit_value=value.
- Flush: when the committing entry has flush_now:
  - Commit pulse as normal, and flush=1 for one cycle.
  - All entries invalidated; head=tail=count=0.
  - CDB writes in the same cycle are dropped; allocation is blocked via alloc_ready.
- count: +1 on allocate, -1 on commit; both in one cycle leaves it unchanged. The flush case forces 0.
- Query ports (qa and qb behave identically):
  - If cdb_valid && cdb_tag==q_tag && entry valid: ready=1, value=cdb_value (forwarding).
  - Else ready = entry.valid && entry.done, value = entry.value.
  - Else ready=0, value=0.
- Pointers wrap 7→0. The full/empty distinction comes from count, not from the pointers.

Test Plan:
- Reset, then allocate 3 ops (add rd=1, sub rd=2, mul rd=3) -> tags 0, 1, 2; count=3. CDB tag 1=0x0005, then tag 0=0x0003 -> commits in order: tag0 rd=1 0x0003, then tag1 rd=2 0x0005 on consecutive cycles; tag2 is held.
- Allocate 8 entries -> full=1, alloc_ready=0; a 9th alloc_valid is ignored. Complete and commit the head while alloc_valid stays high -> one cycle later alloc_ready=1, the next tag is 0 (wrap), count returns to 8.
- Query qa_tag=4 while cdb_valid, tag 4, 0x00AB -> qa_ready=1, qa_value=0x00AB in the same cycle; the next cycle reads the same from storage.
- Allocate beq (tag0), add (tag1), store (tag2); CDB tag1 and tag2 done, then tag0 done with mispredict=1 -> tag0 commits with commit_wen=0 and flush=1. Following cycle: count=0, empty=1, no commit of tags 1/2. Next allocation gets tag 0.
- Store commit -> commit_store=1, commit_wen=0, commit_rd equals the allocated address field. Load commit -> commit_wen=1.
- Drop rst_n asynchronously between clock edges with 5 entries pending -> outputs clear immediately; after release, empty=1 and no spurious commit_valid.

Source files
------------

// File: rtl/tomasulo_rob.sv
// Reorder buffer: in-order allocation, CDB result capture, operand lookup with
// same-cycle forwarding, in-order single retire and a full flush on a mispredicted branch.
module tomasulo_rob #(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = 3,
   parameter int DATA_W = 16,
   parameter int REG_W  = 4
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic [3:0]        alloc_func,
   input  logic [REG_W-1:0]  alloc_rd,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_value,
   input  logic              cdb_mispredict,
   input  logic [TAG_W-1:0]  qa_tag,
   input  logic [TAG_W-1:0]  qb_tag,
   output logic              qa_ready,
   output logic              qb_ready,
   output logic [DATA_W-1:0] qa_value,
   output logic [DATA_W-1:0] qb_value,
   output logic              commit_valid,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [REG_W-1:0]  commit_rd,
   output logic [DATA_W-1:0] commit_value,
   output logic              commit_wen,
   output logic              commit_store,
   output logic              flush,
   output logic [TAG_W:0]    count,
   output logic              empty,
   output logic              full
);

   localparam logic [3:0] F_LOAD  = 4'b0100;
   localparam logic [3:0] F_STORE = 4'b0101;
   localparam logic [3:0] F_BEQ   = 4'b0110;
   localparam logic [3:0] F_BNEQ  = 4'b0111;

   logic [DEPTH-1:0]  e_valid;
   logic [DEPTH-1:0]  e_done;
   logic [DEPTH-1:0]  e_misp;
   logic [3:0]        e_func  [DEPTH];
   logic [REG_W-1:0]  e_rd    [DEPTH];
   logic [DATA_W-1:0] e_value [DEPTH];

   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;

   logic commit_now;
   logic flush_now;
   logic alloc_fire;

   // Handshake: a transfer happens on the rising edge where alloc_valid && alloc_ready;
   // alloc_ready never depends on alloc_valid, and alloc_tag is the tag of that transfer.
   assign commit_now  = e_valid[head] && e_done[head];
   assign flush_now   = commit_now && e_misp[head] &&
                        (e_func[head] == F_BEQ || e_func[head] == F_BNEQ);
   assign empty       = (count == '0);
   assign full        = (count == (TAG_W+1)'(DEPTH));
   assign alloc_ready = !full && !flush_now;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign alloc_tag   = tail;

   // A broadcast in flight for a live entry takes precedence over stored state.
   function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
      logic [DATA_W:0] r;
      r = '0;
      if (cdb_valid && cdb_tag == t && e_valid[t])
         r = {1'b1, cdb_value};
      else if (e_valid[t] && e_done[t])
         r = {1'b1, e_value[t]};
      return r;
   endfunction

   always_comb begin
      {qa_ready, qa_value} = lookup(qa_tag);
      {qb_ready, qb_value} = lookup(qb_tag);
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         e_valid      <= '0;
         e_done       <= '0;
         e_misp       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_func[i]  <= '0;
            e_rd[i]    <= '0;
            e_value[i] <= '0;
         end
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         commit_valid <= 1'b0;
         commit_tag   <= '0;
         commit_rd    <= '0;
         commit_value <= '0;
         commit_wen   <= 1'b0;
         commit_store <= 1'b0;
         flush        <= 1'b0;
      end else begin
         commit_valid <= 1'b0;
         flush        <= 1'b0;
         if (commit_now) begin
            commit_valid <= 1'b1;
            commit_tag   <= head;
            commit_rd    <= e_rd[head];
            commit_value <= e_value[head];
            commit_wen   <= (e_func[head] <= F_LOAD);
            commit_store <= (e_func[head] == F_STORE);
         end
         if (flush_now) begin
            // Everything younger than the branch is wrong-path work.
            e_valid <= '0;
            e_done  <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            flush   <= 1'b1;
         end else begin
            if (cdb_valid && e_valid[cdb_tag]) begin
               e_done[cdb_tag]  <= 1'b1;
               e_value[cdb_tag] <= cdb_value;
               e_misp[cdb_tag]  <= cdb_mispredict;
            end
            if (alloc_fire) begin
               e_valid[tail] <= 1'b1;
               e_done[tail]  <= 1'b0;
               e_misp[tail]  <= 1'b0;
               e_func[tail]  <= alloc_func;
               e_rd[tail]    <= alloc_rd;
               tail          <= tail + 1'b1;
            end
            if (commit_now) begin
               e_valid[head] <= 1'b0;
               head          <= head + 1'b1;
            end
            case ({alloc_fire, commit_now})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tomasulo_rob.sv
// Directed bench for tomasulo_rob: allocation/tags, CDB capture, in-order retire,
// full/wrap, forwarding queries, mispredict flush, store/load retire and async reset.
module tb_tomasulo_rob;

   localparam int TAG_W  = 3;
   localparam int DATA_W = 16;
   localparam int REG_W  = 4;
   localparam int W      = TAG_W + REG_W + DATA_W;

   logic              clk1 = 1'b0;
   logic              rst_n;
   logic              alloc_valid;
   logic              alloc_ready;
   logic [3:0]        alloc_func;
   logic [REG_W-1:0]  alloc_rd;
   logic [TAG_W-1:0]  alloc_tag;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_value;
   logic              cdb_mispredict;
   logic [TAG_W-1:0]  qa_tag, qb_tag;
   logic              qa_ready, qb_ready;
   logic [DATA_W-1:0] qa_value, qb_value;
   logic              commit_valid;
   logic [TAG_W-1:0]  commit_tag;
   logic [REG_W-1:0]  commit_rd;
   logic [DATA_W-1:0] commit_value;
   logic              commit_wen, commit_store, flush;
   logic [TAG_W:0]    count;
   logic              empty, full;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   tomasulo_rob dut (
      .clk1(clk1), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_func(alloc_func),
      .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_mispredict(cdb_mispredict),
      .qa_tag(qa_tag), .qb_tag(qb_tag), .qa_ready(qa_ready), .qb_ready(qb_ready),
      .qa_value(qa_value), .qb_value(qb_value),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
      .commit_value(commit_value), .commit_wen(commit_wen), .commit_store(commit_store),
      .flush(flush), .count(count), .empty(empty), .full(full)
   );

   // clock / reset
   always #5 clk1 = ~clk1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk1);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid    = 1'b0;
      alloc_func     = '0;
      alloc_rd       = '0;
      cdb_valid      = 1'b0;
      cdb_tag        = '0;
      cdb_value      = '0;
      cdb_mispredict = 1'b0;
      qa_tag         = '0;
      qb_tag         = '0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      cycle();
      cycle();
      #2 rst_n = 1'b1;
      cycle();
   endtask

   // driver tasks
   task automatic do_alloc(input logic [3:0] func, input logic [REG_W-1:0] rd,
                           input logic [TAG_W-1:0] exp_tag);
      alloc_valid = 1'b1;
      alloc_func  = func;
      alloc_rd    = rd;
      #1;
      check("alloc_ready", alloc_ready, 1);
      check("alloc_tag", alloc_tag, exp_tag);
      cycle();
      alloc_valid = 1'b0;
   endtask

   task automatic do_cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val,
                         input logic misp);
      cdb_valid      = 1'b1;
      cdb_tag        = tag;
      cdb_value      = val;
      cdb_mispredict = misp;
      cycle();
      cdb_valid      = 1'b0;
      cdb_mispredict = 1'b0;
   endtask

   initial begin
      logic [W-1:0] rec;
      int ncommit;
      rst_n = 1'b0;
      idle_inputs();
      #12;
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_alloc_ready", alloc_ready, 1);
      check("rst_count", count, 0);
      check("rst_commit_valid", commit_valid, 0);
      check("rst_flush", flush, 0);
      check("rst_qa_ready", qa_ready, 0);
      rst_n = 1'b1;
      cycle();

      // in-order retire with out-of-order completion
      do_alloc(4'b0000, 4'd1, 3'd0);
      do_alloc(4'b0001, 4'd2, 3'd1);
      do_alloc(4'b0010, 4'd3, 3'd2);
      check("t1_count3", count, 3);
      do_cdb(3'd1, 16'h0005, 1'b0);
      check("t1_no_early_commit", commit_valid, 0);
      do_cdb(3'd0, 16'h0003, 1'b0);
      check("t1_cdb_head_not_same_edge", commit_valid, 0);
      exp_q.push_back({3'd0, 4'd1, 16'h0003});
      exp_q.push_back({3'd1, 4'd2, 16'h0005});
      ncommit = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (commit_valid) begin
            ncommit++;
            if (exp_q.size() > 0) begin
               rec = exp_q.pop_front();
               check("t1_commit_rec", {commit_tag, commit_rd, commit_value}, rec);
               check("t1_commit_wen", commit_wen, 1);
            end else begin
               check("t1_unexpected_commit", commit_valid, 0);
            end
         end
      end
      check("t1_commit_count", ncommit, 2);
      check("t1_q_drained", exp_q.size(), 0);
      check("t1_count1", count, 1);

      // fill to full, refuse, retire head, wrap tag
      apply_reset();
      for (int i = 0; i < 8; i++) do_alloc(4'b0000, 4'(i), 3'(i));
      check("t2_full", full, 1);
      check("t2_alloc_ready0", alloc_ready, 0);
      check("t2_count8", count, 8);
      check("t2_empty0", empty, 0);
      alloc_valid = 1'b1;
      alloc_func  = 4'b0000;
      alloc_rd    = 4'd9;
      cdb_valid   = 1'b1;
      cdb_tag     = 3'd0;
      cdb_value   = 16'h0033;
      cycle();
      cdb_valid = 1'b0;
      check("t2_9th_ignored_count", count, 8);
      check("t2_still_refused", alloc_ready, 0);
      cycle();
      check("t2_commit_valid", commit_valid, 1);
      check("t2_commit_tag", commit_tag, 0);
      check("t2_commit_value", commit_value, 16'h0033);
      check("t2_count7", count, 7);
      check("t2_alloc_ready1", alloc_ready, 1);
      check("t2_wrap_tag", alloc_tag, 0);
      cycle();
      alloc_valid = 1'b0;
      check("t2_count_back8", count, 8);
      check("t2_full_again", full, 1);
      check("t2_commit_pulse_once", commit_valid, 0);

      // query forwarding, then storage read
      qa_tag    = 3'd4;
      qb_tag    = 3'd5;
      cdb_valid = 1'b1;
      cdb_tag   = 3'd4;
      cdb_value = 16'h00AB;
      #1;
      check("t3_fwd_ready", qa_ready, 1);
      check("t3_fwd_value", qa_value, 16'h00AB);
      check("t3_qb_not_ready", qb_ready, 0);
      check("t3_qb_value0", qb_value, 0);
      cycle();
      cdb_valid = 1'b0;
      qb_tag    = 3'd4;
      #1;
      check("t3_stored_ready", qa_ready, 1);
      check("t3_stored_value", qa_value, 16'h00AB);
      check("t3_qb_stored_value", qb_value, 16'h00AB);
      qb_tag = 3'd0;
      #1;
      check("t3_pending_not_ready", qb_ready, 0);

      // mispredicted branch flush
      apply_reset();
      do_alloc(4'b0110, 4'd0, 3'd0);
      do_alloc(4'b0000, 4'd5, 3'd1);
      do_alloc(4'b0101, 4'hA, 3'd2);
      do_cdb(3'd1, 16'h0011, 1'b0);
      do_cdb(3'd2, 16'h0022, 1'b0);
      do_cdb(3'd0, 16'h0001, 1'b1);
      check("t4_alloc_blocked", alloc_ready, 0);
      alloc_valid = 1'b1;
      alloc_func  = 4'b0000;
      alloc_rd    = 4'd3;
      cdb_valid   = 1'b1;
      cdb_tag     = 3'd1;
      cdb_value   = 16'h00EE;
      cycle();
      idle_inputs();
      check("t4_commit_valid", commit_valid, 1);
      check("t4_commit_tag", commit_tag, 0);
      check("t4_commit_wen", commit_wen, 0);
      check("t4_commit_store", commit_store, 0);
      check("t4_commit_value", commit_value, 16'h0001);
      check("t4_flush", flush, 1);
      check("t4_count0", count, 0);
      check("t4_empty", empty, 1);
      cycle();
      check("t4_no_more_commit", commit_valid, 0);
      check("t4_flush_pulse", flush, 0);
      check("t4_still_empty", empty, 1);
      do_alloc(4'b0000, 4'd3, 3'd0);
      check("t4_count1", count, 1);

      // store and load retire
      apply_reset();
      do_alloc(4'b0101, 4'hC, 3'd0);
      do_alloc(4'b0100, 4'd7, 3'd1);
      do_cdb(3'd0, 16'h1234, 1'b0);
      do_cdb(3'd1, 16'h55AA, 1'b0);
      check("t5_store_valid", commit_valid, 1);
      check("t5_store_flag", commit_store, 1);
      check("t5_store_wen", commit_wen, 0);
      check("t5_store_rd", commit_rd, 4'hC);
      check("t5_store_value", commit_value, 16'h1234);
      cycle();
      check("t5_load_valid", commit_valid, 1);
      check("t5_load_tag", commit_tag, 1);
      check("t5_load_wen", commit_wen, 1);
      check("t5_load_store", commit_store, 0);
      check("t5_load_rd", commit_rd, 4'd7);
      check("t5_load_value", commit_value, 16'h55AA);

      // asynchronous reset with entries in flight
      apply_reset();
      for (int i = 0; i < 5; i++) do_alloc(4'b0001, 4'(i + 1), 3'(i));
      do_cdb(3'd0, 16'h0101, 1'b0);
      do_cdb(3'd1, 16'h0202, 1'b0);
      check("t6_commit_before_rst", commit_valid, 1);
      check("t6_count4", count, 4);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_commit_clear", commit_valid, 0);
      check("t6_async_count", count, 0);
      check("t6_async_empty", empty, 1);
      check("t6_async_ready", alloc_ready, 1);
      #3 rst_n = 1'b1;
      cycle();
      check("t6_post_commit", commit_valid, 0);
      check("t6_post_empty", empty, 1);
      cycle();
      check("t6_post_commit2", commit_valid, 0);
      check("t6_post_flush", flush, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
